// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - two-requester round-robin arbiter over a bank of JK cells
//
// Purpose: two requesters share a bank of N_CELLS JK flip-flop cells. Each
// command (hold/reset/set/toggle on one cell) is granted round-robin. It
// produces one cycle of registered j/k strobes and updates the bank. It then
// returns a one-cycle ack to the requester that was granted.
// Optional feature: define JKB_BROADCAST_EN to add bc0/bc1 inputs. These apply
// the granted op to every cell.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   req0/op0/idx0    requester 0 command (held until ack0)
//   bc0              requester 0 broadcast (JKB_BROADCAST_EN only)
//   ack0             requester 0 one-cycle completion pulse
//   req1/op1/idx1    requester 1 command (held until ack1)
//   bc1              requester 1 broadcast (JKB_BROADCAST_EN only)
//   ack1             requester 1 one-cycle completion pulse
//   err              one-cycle pulse with ack: index out of range
//   busy             high while not IDLE
//   j_vec/k_vec      registered per-cell strobes, nonzero only in APPLY
//   q/qb             bank state and its complement
module jk_bank_arbiter #(
    parameter int N_CELLS = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [1:0]         op0,
    input  logic [IDX_W-1:0]   idx0,
`ifdef JKB_BROADCAST_EN
    input  logic               bc0,
`endif
    output logic               ack0,
    input  logic               req1,
    input  logic [1:0]         op1,
    input  logic [IDX_W-1:0]   idx1,
`ifdef JKB_BROADCAST_EN
    input  logic               bc1,
`endif
    output logic               ack1,
    output logic               err,
    output logic               busy,
    output logic [N_CELLS-1:0] j_vec,
    output logic [N_CELLS-1:0] k_vec,
    output logic [N_CELLS-1:0] q,
    output logic [N_CELLS-1:0] qb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_CELLS);

    state_t             state;
    state_t             state_next;
    logic               ptr;
    logic               grant;
    logic               err_pend;
    logic               any_req;
    logic               sel;
    logic [1:0]         sel_op;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_bc;
    logic               in_range;
    logic [N_CELLS-1:0] onehot;
    logic [N_CELLS-1:0] mask;

    // On contention the pointer names the winner; otherwise the lone requester wins.
    always_comb begin
        any_req  = req0 | req1;
        sel      = (req0 & req1) ? ptr : req1;
        sel_op   = sel ? op1 : op0;
        sel_idx  = sel ? idx1 : idx0;
`ifdef JKB_BROADCAST_EN
        sel_bc   = sel ? bc1 : bc0;
`else
        sel_bc   = 1'b0;
`endif
        in_range = {1'b0, sel_idx} < N_LIM;
        onehot   = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            onehot[i] = (sel_idx == IDX_W'(i));
        end
        // An out-of-range index matches no bit, so the mask is already empty.
        mask = sel_bc ? {N_CELLS{1'b1}} : onehot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = APPLY;
            APPLY:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= 1'b0;
            grant    <= 1'b0;
            err_pend <= 1'b0;
            j_vec    <= '0;
            k_vec    <= '0;
            q        <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= sel;
                        j_vec    <= sel_op[1] ? mask : '0;
                        k_vec    <= sel_op[0] ? mask : '0;
                        err_pend <= !in_range && !sel_bc;
                    end
                end
                APPLY: begin
                    // JK next state: set where j & ~q, keep where ~k & q.
                    q     <= (j_vec & ~q) | (~k_vec & q);
                    j_vec <= '0;
                    k_vec <= '0;
                    ack0  <= ~grant;
                    ack1  <= grant;
                    err   <= err_pend;
                end
                DONE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    err  <= 1'b0;
                    ptr  <= ~grant;
                end
                default: begin
                    j_vec <= '0;
                    k_vec <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign qb   = ~q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [2:0] idx0 = 3'd0, idx1 = 3'd0;
    logic       bc0 = 1'b0, bc1 = 1'b0;
    logic       ack0, ack1, err, busy;
    logic [7:0] j_vec, k_vec, q, qb;

    logic       s_req0 = 1'b0;
    logic [1:0] s_op0 = 2'b00;
    logic [2:0] s_idx0 = 3'd0;
    logic       s_ack0, s_ack1, s_err, s_busy;
    logic [5:0] s_j, s_k, s_q, s_qb;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       who;
        logic [7:0] q;
        logic [7:0] j;
        logic [7:0] k;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq = 8'h00;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N_CELLS(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .idx0(idx0),
`ifdef JKB_BROADCAST_EN
        .bc0(bc0),
`endif
        .ack0(ack0),
        .req1(req1), .op1(op1), .idx1(idx1),
`ifdef JKB_BROADCAST_EN
        .bc1(bc1),
`endif
        .ack1(ack1), .err(err), .busy(busy),
        .j_vec(j_vec), .k_vec(k_vec), .q(q), .qb(qb)
    );

    jk_bank_arbiter #(.N_CELLS(6), .IDX_W(3)) dut6 (
        .clk(clk), .rst(rst),
        .req0(s_req0), .op0(s_op0), .idx0(s_idx0),
`ifdef JKB_BROADCAST_EN
        .bc0(1'b0),
`endif
        .ack0(s_ack0),
        .req1(1'b0), .op1(2'b00), .idx1(3'd0),
`ifdef JKB_BROADCAST_EN
        .bc1(1'b0),
`endif
        .ack1(s_ack1), .err(s_err), .busy(s_busy),
        .j_vec(s_j), .k_vec(s_k), .q(s_q), .qb(s_qb)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Present a command and push its expected outcome (reference bank model).
    task automatic issue(input bit r, input logic [1:0] op, input logic [2:0] idx, input bit bc);
        exp_t       e;
        logic [7:0] mask;
        mask = bc ? 8'hFF : (8'h01 << idx);
        e.who = r;
        e.j   = op[1] ? mask : 8'h00;
        e.k   = op[0] ? mask : 8'h00;
        e.err = 1'b0;
        case (op)
            2'b01:   mq = mq & ~mask;
            2'b10:   mq = mq | mask;
            2'b11:   mq = mq ^ mask;
            default: mq = mq;
        endcase
        e.q = mq;
        sb.push_back(e);
        if (r) begin
            req1 = 1'b1; op1 = op; idx1 = idx; bc1 = bc;
        end else begin
            req0 = 1'b1; op0 = op; idx0 = idx; bc0 = bc;
        end
    endtask

    // Wait for the next ack, compare it with the head of the scoreboard, and release that requester.
    task automatic serve(input int exp_lat);
        exp_t       e;
        int         n;
        bit         got;
        logic [7:0] lj, lk;
        got = 0; n = 0; lj = 8'h00; lk = 8'h00;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (ack0 | ack1) got = 1;
            else begin
                lj = j_vec; lk = k_vec;
            end
        end
        n_total++;
        if (!got || sb.size() == 0) begin
            $display("FAIL serve_ack: got=%0d pending=%0d required ack with pending entry", got, sb.size());
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++;
        if ({ack1, ack0} !== (e.who ? 2'b10 : 2'b01))
            $display("FAIL ack_who: got %b required %b", {ack1, ack0}, e.who ? 2'b10 : 2'b01);
        else n_pass++;
        n_total++;
        if (q !== e.q) $display("FAIL q: got %h required %h", q, e.q);
        else n_pass++;
        n_total++;
        if (qb !== ~e.q) $display("FAIL qb: got %h required %h", qb, ~e.q);
        else n_pass++;
        n_total++;
        if (err !== e.err) $display("FAIL err: got %b required %b", err, e.err);
        else n_pass++;
        n_total++;
        if (lj !== e.j || lk !== e.k)
            $display("FAIL jk_apply: got j=%h k=%h required j=%h k=%h", lj, lk, e.j, e.k);
        else n_pass++;
        n_total++;
        if (n != exp_lat) $display("FAIL latency: got %0d required %0d", n, exp_lat);
        else n_pass++;
        if (e.who) begin
            req1 = 1'b0; bc1 = 1'b0;
        end else begin
            req0 = 1'b0; bc0 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (q !== 8'h00 || qb !== 8'hFF) $display("FAIL reset_q: got q=%h qb=%h required 00/ff", q, qb);
        else n_pass++;
        n_total++;
        if (j_vec !== 8'h00 || k_vec !== 8'h00) $display("FAIL reset_jk: got j=%h k=%h required 00", j_vec, k_vec);
        else n_pass++;
        n_total++;
        if ({ack0, ack1, err, busy} !== 4'b0000) $display("FAIL reset_flags: got %b required 0000", {ack0, ack1, err, busy});
        else n_pass++;
        n_total++;
        if (s_q !== 6'h00 || s_qb !== 6'h3F) $display("FAIL reset_q6: got q=%h qb=%h required 00/3f", s_q, s_qb);
        else n_pass++;
        rst = 1'b1;
        mq = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_apply();
        req0 = 1'b1; op0 = 2'b10; idx0 = 3'd2;
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1 || j_vec !== 8'h04) $display("FAIL mid_apply: got busy=%b j=%h required 1/04", busy, j_vec);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (q !== 8'h00 || qb !== 8'hFF) $display("FAIL abort_q: got q=%h qb=%h required 00/ff", q, qb);
        else n_pass++;
        n_total++;
        if ({ack0, ack1, busy, j_vec} !== 11'd0) $display("FAIL abort_flags: got ack=%b%b busy=%b j=%h required 0", ack0, ack1, busy, j_vec);
        else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mq = 8'h00;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({ack0, ack1, busy} !== 3'b000 || q !== 8'h00)
                $display("FAIL post_reset_idle: got ack=%b%b busy=%b q=%h required idle/00", ack0, ack1, busy, q);
            else n_pass++;
        end
    endtask

    task automatic test_single_set();
        issue(1'b0, 2'b10, 3'd3, 1'b0);
        serve(2);
        @(negedge clk);
        n_total++;
        if ({ack0, ack1, busy} !== 3'b000) $display("FAIL ack_one_cycle: got ack=%b%b busy=%b required 000", ack0, ack1, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b11, 3'd3, 1'b0);
        serve(2);
        issue(1'b1, 2'b11, 3'd0, 1'b0);
        serve(3);
    endtask

    task automatic test_contention();
        @(negedge clk);
        issue(1'b0, 2'b01, 3'd0, 1'b0);
        issue(1'b1, 2'b10, 3'd1, 1'b0);
        serve(2);
        serve(3);
        @(negedge clk);
        issue(1'b0, 2'b00, 3'd4, 1'b0);
        issue(1'b1, 2'b00, 3'd4, 1'b0);
        serve(2);
        serve(3);
    endtask

    task automatic test_hold_and_range();
        logic [2:0] bad_idx [2];
        @(negedge clk);
        issue(1'b0, 2'b00, 3'd5, 1'b0);
        serve(2);
        @(negedge clk);
        s_req0 = 1'b1; s_op0 = 2'b10; s_idx0 = 3'd5;
        @(negedge clk);
        n_total++;
        if (s_j !== 6'h20 || s_k !== 6'h00 || s_busy !== 1'b1) $display("FAIL last_cell_apply: got j=%h k=%h busy=%b required 20/00/1", s_j, s_k, s_busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (s_ack0 !== 1'b1 || s_err !== 1'b0 || s_q !== 6'h20) $display("FAIL last_cell_done: got ack=%b err=%b q=%h required 1/0/20", s_ack0, s_err, s_q);
        else n_pass++;
        s_req0 = 1'b0;
        bad_idx[0] = 3'd6;
        bad_idx[1] = 3'd7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_req0 = 1'b1; s_op0 = 2'b11; s_idx0 = bad_idx[i];
            @(negedge clk);
            n_total++;
            if (s_j !== 6'h00 || s_k !== 6'h00 || s_busy !== 1'b1) $display("FAIL oor_apply idx=%0d: got j=%h k=%h busy=%b required 00/00/1", bad_idx[i], s_j, s_k, s_busy);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (s_ack0 !== 1'b1 || s_err !== 1'b1 || s_q !== 6'h20) $display("FAIL oor_done idx=%0d: got ack=%b err=%b q=%h required 1/1/20", bad_idx[i], s_ack0, s_err, s_q);
            else n_pass++;
            s_req0 = 1'b0;
        end
    endtask

`ifdef JKB_BROADCAST_EN
    task automatic test_broadcast();
        @(negedge clk);
        issue(1'b1, 2'b10, 3'd0, 1'b1);
        serve(2);
        @(negedge clk);
        issue(1'b1, 2'b11, 3'd7, 1'b1);
        serve(2);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_apply();
        test_single_set();
        test_back_to_back();
        test_contention();
        test_hold_and_range();
`ifdef JKB_BROADCAST_EN
        test_broadcast();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
